// File: rtl/datapath_run_controller.sv
// Run/step sequencer for the demo DataPath: holds it in reset, issues one-cycle step enables,
// shadows the datapath outputs after each step and halts once the PC stops moving.
module datapath_run_controller #(
    parameter int STEP_DIV    = 50_000_000,
    parameter int RST_CYCLES  = 4,
    parameter int STALL_LIMIT = 3,
    parameter int DATA_W      = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Run,
    input  logic              StepBtn,
    input  logic              Clear,
    input  logic              DispSel,
    input  logic [DATA_W-1:0] ProgramCount,
    input  logic [DATA_W-1:0] Current_Min,
    input  logic [DATA_W-1:0] XOut,
    input  logic [DATA_W-1:0] YOut,
    output logic              DP_Rst,
    output logic              DP_En,
    output logic [15:0]       NumberA,
    output logic [15:0]       NumberB,
    output logic              Halted,
    output logic [15:0]       StepCount
);

    // state  | meaning
    // S_INIT | DataPath held in reset for RST_CYCLES cycles
    // S_IDLE | paused, waiting for Run or a step request
    // S_RUN  | free-running, DP_En once per STEP_DIV cycles
    // S_STEP | single DP_En pulse, then back to IDLE
    // S_HALT | PC stalled, no more steps until Rst/Clear
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RUN, S_STEP, S_HALT} state_t;

    localparam int PW = $clog2(STEP_DIV);
    localparam int IW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);

    state_t             state, state_nxt;
    logic [PW-1:0]      presc;
    logic [IW-1:0]      init_cnt;
    logic [SW-1:0]      stall_cnt;
    logic               step_btn_q;
    logic               dp_en_q;
    logic               step_req;
    logic               restart;
    logic [DATA_W-1:0]  shadow_pc;
    logic [15:0]        shadow_min;
    logic [15:0]        shadow_x;
    logic [15:0]        shadow_y;
    logic               unused_hi_bits;

    assign restart  = Rst | Clear;
    assign step_req = StepBtn & ~step_btn_q;

    // Only the low half of the value inputs reaches the display.
    assign unused_hi_bits = ^{Current_Min[DATA_W-1:16], XOut[DATA_W-1:16], YOut[DATA_W-1:16]};

    always_ff @(posedge Clk) begin
        if (restart) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT: if (init_cnt == IW'(RST_CYCLES)) state_nxt = S_IDLE;
            S_IDLE: begin
                if (Run) begin
                    state_nxt = S_RUN;
                end else if (step_req) begin
                    state_nxt = S_STEP;
                end
            end
            S_RUN:  if (!Run) state_nxt = S_IDLE;
            S_STEP: state_nxt = S_IDLE;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_INIT;
        endcase
        // A stalled PC overrides any pending run/step decision.
        if (stall_cnt == SW'(STALL_LIMIT)) state_nxt = S_HALT;
    end

    always_comb begin
        DP_Rst = 1'b0;
        DP_En  = 1'b0;
        Halted = 1'b0;
        case (state)
            S_INIT: DP_Rst = 1'b1;
            S_RUN:  DP_En  = Run && (presc == PW'(STEP_DIV - 1));
            S_STEP: DP_En  = 1'b1;
            S_HALT: Halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (restart) begin
            presc      <= '0;
            init_cnt   <= '0;
            stall_cnt  <= '0;
            step_btn_q <= 1'b0;
            dp_en_q    <= 1'b0;
            shadow_pc  <= '0;
            shadow_min <= '0;
            shadow_x   <= '0;
            shadow_y   <= '0;
            StepCount  <= '0;
            NumberA    <= '0;
            NumberB    <= '0;
        end else begin
            step_btn_q <= StepBtn;
            dp_en_q    <= DP_En;

            if (state == S_INIT && init_cnt != IW'(RST_CYCLES)) begin
                init_cnt <= init_cnt + 1'b1;
            end

            if (state == S_RUN && Run) begin
                presc <= (presc == PW'(STEP_DIV - 1)) ? '0 : presc + 1'b1;
            end else begin
                presc <= '0;
            end

            // The DataPath updates on the DP_En edge, so its new values are valid one cycle later.
            if (dp_en_q) begin
                shadow_pc  <= ProgramCount;
                shadow_min <= Current_Min[15:0];
                shadow_x   <= XOut[15:0];
                shadow_y   <= YOut[15:0];
                if (StepCount != 16'hFFFF) StepCount <= StepCount + 1'b1;
                if (ProgramCount == shadow_pc) begin
                    if (stall_cnt != SW'(STALL_LIMIT)) stall_cnt <= stall_cnt + 1'b1;
                end else begin
                    stall_cnt <= '0;
                end
            end

            NumberA <= DispSel ? shadow_x : shadow_pc[15:0];
            NumberB <= DispSel ? shadow_y : shadow_min;
        end
    end

endmodule
